led_sweep_ctrl: RTL and testbench

LED_SWEEP_CTRL -- requirements
Module: led_sweep_ctrl

---
 rtl/led_sweep_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_led_sweep_ctrl.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// led_sweep_ctrl
//
// Control block for an LED sweep: it turns two raw push buttons into clean
// press events, runs a small IDLE/RUN/PAUSED state machine and produces a
// clock-enable pulse ("step") that advances an external position counter.
//
// Optional build macro: BOUNCE_MODE_EN
//   undefined : wrap mode, direction is toggled only by the direction button.
//   defined   : bounce mode, direction reverses automatically at pos==max_out
//               (counting up) and at pos==0 (counting down); the direction
//               button is ignored.
//
// Parameters
//   PRESCALE_BASE   : base clock cycles per step (2 .. 2^20)
//   DEBOUNCE_CYCLES : consecutive stable samples to accept a level (1 .. 255)
//
// Ports
//   clk        in   sole clock, rising edge
//   rst        in   asynchronous, active-high reset
//   btn_pause  in   raw button, each accepted press toggles run/pause
//   btn_dir    in   raw button, each accepted press toggles direction
//   speed_sel  in   [1:0] step rate select, 3 is fastest
//   max_in     in   [7:0] requested wrap limit
//   pos        in   [7:0] current position from the position counter
//   step       out  one-cycle enable pulse for the position counter
//   direction  out  1 = count up, 0 = count down
//   pause      out  1 = counter must hold
//   max_out    out  [7:0] wrap limit presented to the counter
//   state      out  [1:0] FSM state: 00 IDLE, 01 RUN, 10 PAUSED
//
// Handshake: there is no valid/ready pair here. "step" is a single-cycle
// enable: the counter consumes it on the rising edge that ends the cycle in
// which step is high; it is never held for more than one cycle.
// ---------------------------------------------------------------------------
module led_sweep_ctrl #(
  parameter int PRESCALE_BASE   = 16,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_pause,
  input  logic       btn_dir,
  input  logic [1:0] speed_sel,
  input  logic [7:0] max_in,
  input  logic [7:0] pos,
  output logic       step,
  output logic       direction,
  output logic       pause,
  output logic [7:0] max_out,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    PAUSED = 2'b10
  } state_t;

  localparam logic [7:0]  DB_LAST = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [23:0] BASE    = 24'(PRESCALE_BASE);

  state_t      state_q;
  state_t      state_d;

  // Button conditioning. Index 0 = pause button, index 1 = direction button.
  logic [1:0]  btn_raw;
  logic [1:0]  sync0;
  logic [1:0]  sync1;
  logic [1:0]  clean;
  logic [1:0]  clean_d;
  logic [1:0]  armed;
  logic [7:0]  db_cnt [2];
  logic [1:0]  warm;
  logic        warm_done;
  logic [1:0]  press;
  logic        press_pause;
  logic        press_dir;

  logic [23:0] presc;
  logic [23:0] period;
  logic [23:0] period_m1;
  logic        running;

  assign btn_raw     = {btn_dir, btn_pause};
  // The synchronizer output only reflects the real pin after two edges.
  assign warm_done   = (warm == 2'd2);
  // A rising clean level is a press only once the button has been seen
  // released since reset, so a button held through reset stays silent.
  assign press       = clean & ~clean_d & armed;
  assign press_pause = press[0];
  assign press_dir   = press[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync0     <= 2'b00;
      sync1     <= 2'b00;
      clean     <= 2'b00;
      clean_d   <= 2'b00;
      armed     <= 2'b00;
      db_cnt[0] <= 8'd0;
      db_cnt[1] <= 8'd0;
      warm      <= 2'd0;
    end else begin
      sync0   <= btn_raw;
      sync1   <= sync0;
      clean_d <= clean;
      if (!warm_done) begin
        warm <= warm + 2'd1;
      end
      for (int i = 0; i < 2; i++) begin
        // The counter tracks how long the synchronized level has disagreed
        // with the clean level; any agreeing sample restarts it.
        if (sync1[i] == clean[i]) begin
          db_cnt[i] <= 8'd0;
        end else if (db_cnt[i] == DB_LAST) begin
          clean[i]  <= sync1[i];
          db_cnt[i] <= 8'd0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 8'd1;
        end
        if (warm_done && !sync1[i] && !clean[i]) begin
          armed[i] <= 1'b1;
        end
      end
    end
  end

  // State machine
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (press_pause) state_d = RUN;
      RUN:     if (press_pause) state_d = PAUSED;
      PAUSED:  if (press_pause) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  assign running = (state_q == RUN);
  assign state   = state_q;
  assign pause   = !running;

  // Step prescaler
  assign period    = BASE << (2'd3 - speed_sel);
  assign period_m1 = period - 24'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= 24'd0;
    end else if (!running || state_d != RUN) begin
      presc <= 24'd0;
    end else if (presc >= period_m1) begin
      // Also catches a count left above a freshly shortened period: it wraps
      // without a step because step only fires on exact equality.
      presc <= 24'd0;
    end else begin
      presc <= presc + 24'd1;
    end
  end

  assign step = running && (presc == period_m1);

  // Wrap limit: follows max_in while the counter is stopped, frozen in RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_out <= 8'd15;
    end else if (!running) begin
      max_out <= max_in;
    end
  end

  // Direction
`ifdef BOUNCE_MODE_EN
  logic unused_press_dir;
  assign unused_press_dir = press_dir;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      direction <= 1'b1;
    end else if (running) begin
      // The low end wins so that max_out == 0 settles on counting up
      // instead of flipping every cycle at pos == 0.
      if (!direction && pos == 8'd0) begin
        direction <= 1'b1;
      end else if (direction && pos == max_out && max_out != 8'd0) begin
        direction <= 1'b0;
      end
    end
  end
`else
  logic unused_pos;
  assign unused_pos = ^pos;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      direction <= 1'b1;
    end else if (press_dir) begin
      direction <= ~direction;
    end
  end
`endif

endmodule

// File: tb/tb_led_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// Bench for led_sweep_ctrl. Inputs change 1 time unit after a falling edge,
// outputs are sampled on falling edges by a monitor that timestamps events
// (steps, state changes, direction changes) with a falling-edge cycle count.
// Expected values come from the rules of the block: step period
// P = 16 << (3 - speed_sel), first step P-1 sampled cycles after the first
// cycle seen in RUN (consumed on the P-th edge after entry), buttons need at
// least 4 stable samples to count.
// ---------------------------------------------------------------------------
module tb_led_sweep_ctrl;

  localparam int PB = 16;
  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_pause = 1'b0;
  logic       btn_dir = 1'b0;
  logic [1:0] speed_sel = 2'd3;
  logic [7:0] max_in = 8'd15;
  logic [7:0] pos = 8'd100;
  logic       step;
  logic       direction;
  logic       pause;
  logic [7:0] max_out;
  logic [1:0] state;

  int errors = 0;
  int checks = 0;

  // Monitor records
  int          cyc = 0;
  logic [31:0] step_q[$];
  logic [31:0] exp_q[$];
  int          st_change_cyc = 0;
  int          dir_change_cyc = 0;
  int          dir_toggles = 0;
  logic [1:0]  st_prev = 2'b00;
  logic        dir_prev = 1'b1;

  // Model state
  logic       exp_dir = 1'b1;
  logic [7:0] exp_max = 8'd15;

  led_sweep_ctrl #(
    .PRESCALE_BASE  (PB),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_pause(btn_pause),
    .btn_dir  (btn_dir),
    .speed_sel(speed_sel),
    .max_in   (max_in),
    .pos      (pos),
    .step     (step),
    .direction(direction),
    .pause    (pause),
    .max_out  (max_out),
    .state    (state)
  );

  // Clock
  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (step === 1'b1) step_q.push_back(32'(cyc));
    if (direction !== dir_prev) begin
      dir_toggles++;
      dir_change_cyc = cyc;
    end
    dir_prev = direction;
    if (state !== st_prev) st_change_cyc = cyc;
    st_prev = state;
  end

  function automatic int period(input int sel);
    return PB << (3 - sel);
  endfunction

  // Driver tasks
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic press(input logic pb, input logic db, input int hold, input int total);
    for (int i = 0; i < total; i++) begin
      btn_pause = pb && (i < hold);
      btn_dir   = db && (i < hold);
      tick(1);
    end
    btn_pause = 1'b0;
    btn_dir   = 1'b0;
  endtask

  // Tests
  task automatic test_reset();
    max_in = 8'h5A;
    #1 rst = 1'b1;
    tick(3);
    checks++; if (state !== 2'b00) $display("FAIL rst_state got=%b exp=00", state);
    if (state !== 2'b00) errors++;
    checks++; if (pause !== 1'b1) begin errors++; $display("FAIL rst_pause got=%b exp=1", pause); end
    checks++; if (direction !== 1'b1) begin errors++; $display("FAIL rst_dir got=%b exp=1", direction); end
    checks++; if (max_out !== 8'd15) begin errors++; $display("FAIL rst_max got=%0d exp=15", max_out); end
    checks++; if (step !== 1'b0) begin errors++; $display("FAIL rst_step got=%b exp=0", step); end
    max_in = 8'd15;
    rst = 1'b0;
    step_q.delete();
    tick(100);
    checks++; if (step_q.size() != 0) begin errors++; $display("FAIL idle_steps got=%0d exp=0", step_q.size()); end
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL idle_state got=%b exp=00", state); end
    checks++; if (pause !== 1'b1) begin errors++; $display("FAIL idle_pause got=%b exp=1", pause); end
    checks++; if (direction !== 1'b1) begin errors++; $display("FAIL idle_dir got=%b exp=1", direction); end
    checks++; if (max_out !== 8'd15) begin errors++; $display("FAIL idle_max got=%0d exp=15", max_out); end
    exp_dir = 1'b1;
    exp_max = 8'd15;
  endtask

  task automatic test_start_rate();
    int entry;
    int base;
    int p;
    speed_sel = 2'd3;
    step_q.delete();
    press(1'b1, 1'b0, 6, 16);
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL start_state got=%b exp=01", state); end
    checks++; if (pause !== 1'b0) begin errors++; $display("FAIL start_pause got=%b exp=0", pause); end
    entry = st_change_cyc;
    p = period(3);
    exp_q.delete();
    for (int n = 0; n < 4; n++) exp_q.push_back(32'(entry + p - 1 + n * p));
    while (cyc < entry + 4 * p) tick(1);
    checks++;
    if (step_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rate16_count got=%0d exp=%0d", step_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < step_q.size(); i++) begin
      checks++;
      if (step_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL rate16_cycle[%0d] got=%0d exp=%0d", i, step_q[i], exp_q[i]);
      end
    end
    // entry+4P lands just after a wrap, so the new period counts from zero
    speed_sel = 2'd1;
    p = period(1);
    base = cyc;
    step_q.delete();
    exp_q.delete();
    for (int n = 0; n < 3; n++) exp_q.push_back(32'(base + p - 1 + n * p));
    while (cyc < base + 3 * p) tick(1);
    checks++;
    if (step_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rate64_count got=%0d exp=%0d", step_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < step_q.size(); i++) begin
      checks++;
      if (step_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL rate64_cycle[%0d] got=%0d exp=%0d", i, step_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_speed_change();
    int n0;
    int k;
    int e;
    for (int it = 0; it < 4; it++) begin
      n0 = step_q.size();
      for (int i = 0; i < 300 && step_q.size() == n0; i++) tick(1);
      checks++;
      if (step_q.size() == n0) begin
        errors++; $display("FAIL spd_wait_step it=%0d got=none exp=step", it);
        return;
      end
      tick(1);              // prescaler is 0 in this cycle
      speed_sel = 2'd0;     // P = 128
      if (it == 0) k = $urandom_range(1, 14);
      else if (it == 1) k = $urandom_range(16, 119);
      else begin
        k = $urandom_range(1, 119);
        if (k == 15) k = 16;
      end
      tick(k);              // prescaler now equals k
      speed_sel = 2'd3;     // P = 16
      e = (k > 15) ? cyc + 16 : cyc + (15 - k);
      n0 = step_q.size();
      for (int i = 0; i < 40 && step_q.size() == n0; i++) tick(1);
      checks++;
      if (step_q.size() == n0) begin
        errors++; $display("FAIL spd_change_step k=%0d got=none exp=%0d", k, e);
      end else if (step_q[n0] !== 32'(e)) begin
        errors++; $display("FAIL spd_change_step k=%0d got=%0d exp=%0d", k, step_q[n0], e);
      end
    end
  endtask

  task automatic test_pause_limit();
    int entry;
    int late;
    max_in = 8'd99;
    tick(2);
    checks++; if (max_out !== exp_max) begin errors++; $display("FAIL run_max_frozen got=%0d exp=%0d", max_out, exp_max); end
    step_q.delete();
    press(1'b1, 1'b0, 6, 16);
    checks++; if (state !== 2'b10) begin errors++; $display("FAIL pause_state got=%b exp=10", state); end
    checks++; if (pause !== 1'b1) begin errors++; $display("FAIL pause_out got=%b exp=1", pause); end
    tick(40);
    late = 0;
    foreach (step_q[i]) if (step_q[i] >= 32'(st_change_cyc)) late++;
    checks++; if (late != 0) begin errors++; $display("FAIL pause_steps got=%0d exp=0", late); end
    max_in = 8'd0;
    tick(1);
    checks++; if (max_out !== 8'd0) begin errors++; $display("FAIL max_zero got=%0d exp=0", max_out); end
    max_in = 8'd20;
    tick(1);
    checks++; if (max_out !== 8'd20) begin errors++; $display("FAIL max_20 got=%0d exp=20", max_out); end
    exp_max = 8'd20;
    step_q.delete();
    press(1'b1, 1'b0, 6, 16);
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL resume_state got=%b exp=01", state); end
    entry = st_change_cyc;
    while (cyc < entry + period(3)) tick(1);
    checks++;
    if (step_q.size() == 0) begin
      errors++; $display("FAIL resume_step got=none exp=%0d", entry + period(3) - 1);
    end else if (step_q[0] !== 32'(entry + period(3) - 1)) begin
      errors++; $display("FAIL resume_step got=%0d exp=%0d", step_q[0], entry + period(3) - 1);
    end
    max_in = 8'd77;
    tick(2);
    checks++; if (max_out !== exp_max) begin errors++; $display("FAIL run_max_hold got=%0d exp=%0d", max_out, exp_max); end
  endtask

  task automatic test_debounce();
    int t0;
    int len;
    int exp_n;
    logic lng;
    for (int t = 0; t < 8; t++) begin
      if (t == 0) len = 2;
      else if (t == 1) len = 6;
      else if ($urandom_range(0, 1) == 1) len = $urandom_range(6, 10);
      else len = $urandom_range(1, 2);
      lng = (len >= 6);
      t0 = dir_toggles;
      btn_dir = 1'b1;
      tick(len);
      btn_dir = 1'b0;
      tick(14);
`ifdef BOUNCE_MODE_EN
      exp_n = 0;
`else
      exp_n = lng ? 1 : 0;
      if (lng) exp_dir = ~exp_dir;
`endif
      checks++;
      if (dir_toggles - t0 != exp_n) begin
        errors++; $display("FAIL deb_toggles len=%0d got=%0d exp=%0d", len, dir_toggles - t0, exp_n);
      end
      checks++;
      if (direction !== exp_dir) begin
        errors++; $display("FAIL deb_dir len=%0d got=%b exp=%b", len, direction, exp_dir);
      end
    end
  endtask

  task automatic test_back_to_back();
    int t0;
    t0 = dir_toggles;
    press(1'b1, 1'b1, 6, 16);
    checks++; if (state !== 2'b10) begin errors++; $display("FAIL b2b_state got=%b exp=10", state); end
`ifdef BOUNCE_MODE_EN
    checks++; if (dir_toggles != t0) begin errors++; $display("FAIL b2b_toggles got=%0d exp=0", dir_toggles - t0); end
`else
    exp_dir = ~exp_dir;
    checks++; if (dir_toggles - t0 != 1) begin errors++; $display("FAIL b2b_toggles got=%0d exp=1", dir_toggles - t0); end
    checks++;
    if (dir_change_cyc != st_change_cyc) begin
      errors++; $display("FAIL b2b_same_cycle got=%0d exp=%0d", dir_change_cyc, st_change_cyc);
    end
`endif
    checks++; if (direction !== exp_dir) begin errors++; $display("FAIL b2b_dir got=%b exp=%b", direction, exp_dir); end
  endtask

`ifdef BOUNCE_MODE_EN
  task automatic test_bounce();
    int t0;
    pos = 8'd100;
    max_in = 8'd5;
    tick(1);
    press(1'b1, 1'b0, 6, 16);
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL bnc_state got=%b exp=01", state); end
    checks++; if (max_out !== 8'd5) begin errors++; $display("FAIL bnc_max got=%0d exp=5", max_out); end
    checks++; if (direction !== 1'b1) begin errors++; $display("FAIL bnc_dir0 got=%b exp=1", direction); end
    pos = 8'd5;
    tick(1);
    checks++; if (direction !== 1'b0) begin errors++; $display("FAIL bnc_top got=%b exp=0", direction); end
    pos = 8'd0;
    tick(1);
    checks++; if (direction !== 1'b1) begin errors++; $display("FAIL bnc_bottom got=%b exp=1", direction); end
    pos = 8'd100;
    t0 = dir_toggles;
    press(1'b0, 1'b1, 6, 16);
    checks++; if (dir_toggles != t0) begin errors++; $display("FAIL bnc_btn got=%0d exp=0", dir_toggles - t0); end
    press(1'b1, 1'b0, 6, 16);
    max_in = 8'd0;
    tick(1);
    press(1'b1, 1'b0, 6, 16);
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL bnc_state2 got=%b exp=01", state); end
    pos = 8'd0;
    t0 = dir_toggles;
    tick(6);
    checks++; if (direction !== 1'b1) begin errors++; $display("FAIL bnc_max0_dir got=%b exp=1", direction); end
    checks++; if (dir_toggles != t0) begin errors++; $display("FAIL bnc_max0_toggles got=%0d exp=0", dir_toggles - t0); end
    pos = 8'd100;
    exp_dir = 1'b1;
  endtask
`endif

  task automatic test_async_reset();
    if (state !== 2'b01) press(1'b1, 1'b0, 6, 16);
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL ar_pre_state got=%b exp=01", state); end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL ar_state got=%b exp=00", state); end
    checks++; if (pause !== 1'b1) begin errors++; $display("FAIL ar_pause got=%b exp=1", pause); end
    checks++; if (step !== 1'b0) begin errors++; $display("FAIL ar_step got=%b exp=0", step); end
    checks++; if (direction !== 1'b1) begin errors++; $display("FAIL ar_dir got=%b exp=1", direction); end
    checks++; if (max_out !== 8'd15) begin errors++; $display("FAIL ar_max got=%0d exp=15", max_out); end
    tick(2);
    step_q.delete();
    rst = 1'b0;
    tick(1);
    checks++; if (step_q.size() != 0) begin errors++; $display("FAIL ar_first_cycle got=%0d exp=0", step_q.size()); end
    tick(30);
    checks++; if (step_q.size() != 0) begin errors++; $display("FAIL ar_steps got=%0d exp=0", step_q.size()); end
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL ar_post_state got=%b exp=00", state); end
    exp_dir = 1'b1;
  endtask

  task automatic test_held_reset();
    int t0;
    rst = 1'b1;
    btn_pause = 1'b1;
    btn_dir = 1'b1;
    tick(2);
    rst = 1'b0;
    t0 = dir_toggles;
    tick(30);
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL held_state got=%b exp=00", state); end
    checks++; if (dir_toggles != t0) begin errors++; $display("FAIL held_dir got=%0d exp=0", dir_toggles - t0); end
    btn_pause = 1'b0;
    btn_dir = 1'b0;
    tick(12);
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL held_release got=%b exp=00", state); end
    press(1'b1, 1'b0, 6, 16);
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL held_repress got=%b exp=01", state); end
  endtask

  initial begin
    test_reset();
    test_start_rate();
    test_speed_change();
    test_pause_limit();
    test_debounce();
    test_back_to_back();
`ifdef BOUNCE_MODE_EN
    test_bounce();
`endif
    test_async_reset();
    test_held_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
